icon_sprite_reader: RTL and testbench

Pixel-side reader for the 40x40 icon ROMs (mouse cursor, brick, tank sprites). It consumes the VGA timing generator's pixel coordinates and drives the ROM address for the icon at a latched screen position. It returns the ROM byte as a registered, transparency-keyed pixel for the layer mixer. Address generation is incremental (row base plus column), with no multiplier, and is tracked by a per-frame row state machine.

---
 rtl/icon_pkg.sv | 14 +
 rtl/icon_row_tracker.sv | 89 ++++++++
 rtl/icon_sprite_reader.sv | 89 ++++++++
 tb/tb_icon_sprite_reader.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/icon_pkg.sv
// rtl/icon_pkg.sv - shared icon geometry, transparency key and row-state type
// Purpose: constants and the per-frame row-state encoding used by every
// sprite reader (cursor, brick, tank).
package icon_pkg;
  localparam int         ICON_W     = 40;
  localparam int         ICON_H     = 40;
  localparam logic [7:0] TRANSP_KEY = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } row_state_t;
endpackage

// File: rtl/icon_row_tracker.sv
// rtl/icon_row_tracker.sv - per-frame icon row state machine with incremental row base
// Purpose: follows the raster line by line, enters the icon on the line that
// matches the latched top edge and steps row_base by ICON_W per line.
// Ports:
//   clk, rst     pixel clock, asynchronous active-high reset
//   frame_start  forces IDLE for the coming frame
//   pix_valid    visible pixel qualifier
//   vcount       current line
//   py_q         latched icon top line
//   row_base     row start address seen by the current pixel
//   active       current pixel lies on an icon row
module icon_row_tracker
  import icon_pkg::*;
#(
  parameter int ICON_W  = icon_pkg::ICON_W,
  parameter int ICON_H  = icon_pkg::ICON_H,
  parameter int ADDR_W  = 11,
  parameter int COORD_W = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] vcount,
  input  logic [COORD_W-1:0] py_q,
  output logic [ADDR_W-1:0]  row_base,
  output logic               active
);
  localparam int ROW_W = $clog2(ICON_H);

  row_state_t         state_q, state_d;
  logic [COORD_W-1:0] last_v_q, last_v_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic               new_line;

  assign new_line = pix_valid && (vcount != last_v_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_v_q <= '1;
      row_q    <= '0;
      base_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_v_q <= last_v_d;
      row_q    <= row_d;
      base_q   <= base_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_v_d = last_v_q;
    row_d    = row_q;
    base_d   = base_q;
    if (frame_start) begin
      // Forgetting the previous line makes the first visible pixel of the new
      // frame a new line even if it repeats the last line number seen.
      state_d  = IDLE;
      last_v_d = '1;
    end else if (new_line) begin
      last_v_d = vcount;
      case (state_q)
        IDLE: begin
          if (vcount == py_q) begin
            state_d = ACTIVE;
            row_d   = '0;
            base_d  = '0;
          end
        end
        ACTIVE: begin
          if (row_q == ROW_W'(ICON_H - 1)) begin
            state_d = DONE;
          end else begin
            row_d  = row_q + 1'b1;
            base_d = base_q + ADDR_W'(ICON_W);
          end
        end
        default: ;
      endcase
    end
  end

  // The pixel that causes a row update already belongs to the updated row.
  assign row_base = base_d;
  assign active   = (state_d == ACTIVE);
endmodule

// File: rtl/icon_sprite_reader.sv
// rtl/icon_sprite_reader.sv - 40x40 icon ROM reader producing transparency-keyed pixels
// Purpose: latches the icon position per frame, generates ROM addresses as
// row_base + column and registers the keyed ROM byte two cycles after the pixel.
// Ports:
//   clk, rst                pixel clock, asynchronous active-high reset
//   pix_valid, hcount, vcount   raster position from the timing generator
//   frame_start             pulse before the first visible line; latches pos_x/pos_y
//   pos_x, pos_y            requested icon top-left
//   icon_addr, icon_data    ROM address (registered) and combinational ROM data
//   pix_out, pix_hit, pix_out_valid   keyed pixel, opaque flag, visible qualifier
module icon_sprite_reader
  import icon_pkg::*;
#(
  parameter int                ICON_W     = icon_pkg::ICON_W,
  parameter int                ICON_H     = icon_pkg::ICON_H,
  parameter int                ADDR_W     = 11,
  parameter int                DATA_W     = 8,
  parameter int                COORD_W    = 11,
  parameter logic [DATA_W-1:0] TRANSP_KEY = icon_pkg::TRANSP_KEY
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] hcount,
  input  logic [COORD_W-1:0] vcount,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  output logic [ADDR_W-1:0]  icon_addr,
  input  logic [DATA_W-1:0]  icon_data,
  output logic [DATA_W-1:0]  pix_out,
  output logic               pix_hit,
  output logic               pix_out_valid
);
  logic [COORD_W-1:0] px_q, py_q, col;
  logic [ADDR_W-1:0]  row_base;
  logic               row_active, in_box, in_box_d, valid_d, opaque;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_q <= '0;
      py_q <= '0;
    end else if (frame_start) begin
      px_q <= pos_x;
      py_q <= pos_y;
    end
  end

  icon_row_tracker #(
    .ICON_W  (ICON_W),
    .ICON_H  (ICON_H),
    .ADDR_W  (ADDR_W),
    .COORD_W (COORD_W)
  ) u_row_tracker (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .vcount      (vcount),
    .py_q        (py_q),
    .row_base    (row_base),
    .active      (row_active)
  );

  // Pixels left of the icon wrap to large values and fail the width compare.
  assign col    = hcount - px_q;
  assign in_box = pix_valid && !frame_start && row_active && (col < COORD_W'(ICON_W));
  assign opaque = in_box_d && (icon_data != TRANSP_KEY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icon_addr     <= '0;
      in_box_d      <= 1'b0;
      valid_d       <= 1'b0;
      pix_out       <= '0;
      pix_hit       <= 1'b0;
      pix_out_valid <= 1'b0;
    end else begin
      if (in_box) begin
        icon_addr <= row_base + col[ADDR_W-1:0];
      end
      in_box_d      <= in_box;
      valid_d       <= pix_valid;
      pix_hit       <= opaque;
      pix_out       <= opaque ? icon_data : '0;
      pix_out_valid <= valid_d;
    end
  end
endmodule

// File: tb/tb_icon_sprite_reader.sv
// tb/tb_icon_sprite_reader.sv - self-checking bench for icon_sprite_reader
module tb_icon_sprite_reader;
  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid, frame_start;
  logic [10:0] hcount, vcount, pos_x, pos_y;
  logic [10:0] icon_addr;
  logic [7:0]  icon_data, pix_out;
  logic        pix_hit, pix_out_valid;
  logic [7:0]  rom [0:2047];

  always #5 clk = ~clk;
  assign icon_data = rom[icon_addr];

  icon_sprite_reader dut (
    .clk           (clk),
    .rst           (rst),
    .pix_valid     (pix_valid),
    .hcount        (hcount),
    .vcount        (vcount),
    .frame_start   (frame_start),
    .pos_x         (pos_x),
    .pos_y         (pos_y),
    .icon_addr     (icon_addr),
    .icon_data     (icon_data),
    .pix_out       (pix_out),
    .pix_hit       (pix_hit),
    .pix_out_valid (pix_out_valid)
  );

  typedef struct {
    int fid;
    int h;
    int v;
    int addr;
    int hit;
    int out;
  } probe_t;
  probe_t probes[$];

  int checks = 0;
  int errors = 0;
  int cur_h, cur_v, fid;
  // reference model state: latched position, line ordinal, ordinal of the icon's top line
  int m_px, m_py, m_last_v, m_line_ord, m_act_ord;
  int e_addr, p_hit, p_out, p_valid, pend;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (fid=%0d h=%0d v=%0d)", name, act, exp, fid, cur_h, cur_v);
    end
  endtask

  task automatic model_reset();
    m_px = 0; m_py = 0; m_last_v = -1; m_act_ord = -1;
    e_addr = 0; p_hit = 0; p_out = 0; p_valid = 0; pend = -1;
  endtask

  // One pixel: drive at a negedge, check after the following posedge.
  task automatic step(input bit valid, input int h, input int v, input bit fs,
                      input int px_in, input int py_in);
    int  col, row;
    bit  ib;
    pix_valid = valid; hcount = h[10:0]; vcount = v[10:0];
    frame_start = fs; pos_x = px_in[10:0]; pos_y = py_in[10:0];
    cur_h = h; cur_v = v;
    ib = 0; col = 0; row = 0;
    if (fs) begin
      fid++;
      m_px = px_in; m_py = py_in; m_act_ord = -1; m_last_v = -1;
    end else if (valid) begin
      if (v != m_last_v) begin
        m_line_ord++;
        m_last_v = v;
        if (m_act_ord < 0 && v == m_py) m_act_ord = m_line_ord;
      end
      col = (h - m_px) & 2047;
      if (m_act_ord >= 0) begin
        row = m_line_ord - m_act_ord;
        ib = (row < 40) && (col < 40);
      end
    end
    if (ib) e_addr = row * 40 + col;
    @(negedge clk);
    chk("icon_addr", int'(icon_addr), e_addr);
    chk("pix_hit", int'(pix_hit), p_hit);
    chk("pix_out", int'(pix_out), p_out);
    chk("pix_out_valid", int'(pix_out_valid), p_valid);
    if (pend >= 0) begin
      chk("probe_hit", int'(pix_hit), probes[pend].hit);
      chk("probe_out", int'(pix_out), probes[pend].out);
      pend = -1;
    end
    p_hit   = (ib && rom[e_addr] != 8'hFF) ? 1 : 0;
    p_out   = p_hit ? int'(rom[e_addr]) : 0;
    p_valid = valid;
    foreach (probes[k]) begin
      if (probes[k].fid == fid && probes[k].h == h && probes[k].v == v && valid) begin
        chk("probe_addr", int'(icon_addr), probes[k].addr);
        pend = k;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_icon_addr", int'(icon_addr), 0);
    chk("rst_pix_hit", int'(pix_hit), 0);
    chk("rst_pix_out", int'(pix_out), 0);
    chk("rst_pix_out_valid", int'(pix_out_valid), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_frame(input int px_in, input int py_in);
    step(1'b0, 0, 0, 1'b1, px_in, py_in);
  endtask

  // Raster over a window; pos inputs switch to (chg_x,chg_y) from line chg_v on.
  task automatic scan(input int h0, input int h1, input int v0, input int v1,
                      input int px_in, input int py_in,
                      input int chg_v, input int chg_x, input int chg_y,
                      input bit rnd, input int rst_v, input int rst_h);
    int  ax, ay;
    bit  valid;
    for (int v = v0; v <= v1; v++) begin
      for (int h = h0; h <= h1; h++) begin
        if (v == rst_v && h == rst_h) do_reset();
        valid = rnd ? ($urandom_range(9) != 0) : 1'b1;
        ax = (v >= chg_v) ? chg_x : px_in;
        ay = (v >= chg_v) ? chg_y : py_in;
        if (rnd) begin
          ax = $urandom_range(2047);
          ay = $urandom_range(2047);
        end
        step(valid, h, v, 1'b0, ax, ay);
      end
      for (int b = 0; b < 2; b++) step(1'b0, h1 + 1 + b, v, 1'b0, px_in, py_in);
    end
  endtask

  initial begin
    int rx, ry;
    for (int i = 0; i < 2048; i++) rom[i] = 8'(i);
    rom[0] = 8'hFF;

    probes.push_back('{1, 100,  50,    0, 0, 0});
    probes.push_back('{1, 101,  50,    1, 1, 1});
    probes.push_back('{1, 139,  89, 1599, 1, 63});
    probes.push_back('{1, 140,  89, 1599, 0, 0});
    probes.push_back('{1, 139,  90, 1599, 0, 0});
    probes.push_back('{1,  99,  50,    0, 0, 0});
    probes.push_back('{2, 100,  50, 1599, 0, 0});
    probes.push_back('{2, 200, 200,    0, 0, 0});
    probes.push_back('{2, 201, 200,    1, 1, 1});
    probes.push_back('{3, 780,  50,    0, 0, 0});
    probes.push_back('{3, 799,  50,   19, 1, 19});
    probes.push_back('{3, 780,  51,   40, 1, 40});
    probes.push_back('{3, 785,  90, 1579, 0, 0});
    probes.push_back('{5, 100,  50,    0, 0, 0});
    probes.push_back('{5, 101,  50,    1, 1, 1});
    probes.push_back('{6, 100,  50,  119, 0, 0});

    fid = 0; m_line_ord = 0; cur_h = 0; cur_v = 0;
    model_reset();
    rst = 1'b1; pix_valid = 1'b0; frame_start = 1'b0;
    hcount = '0; vcount = '0; pos_x = '0; pos_y = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_icon_addr", int'(icon_addr), 0);
    chk("reset_pix_hit", int'(pix_hit), 0);
    chk("reset_pix_out", int'(pix_out), 0);
    chk("reset_pix_out_valid", int'(pix_out_valid), 0);
    rst = 1'b0;

    // frame 1: icon at (100,50); requested position moves at line 60 but must not apply
    start_frame(100, 50);
    scan(90, 149, 45, 95, 100, 50, 60, 200, 200, 1'b0, -1, -1);
    // frame 2: the new position takes effect
    start_frame(200, 200);
    scan(95, 210, 48, 52, 200, 200, 9999, 0, 0, 1'b0, -1, -1);
    scan(95, 210, 198, 202, 200, 200, 9999, 0, 0, 1'b0, -1, -1);
    // frame 3: right edge clipping on an 800-wide line
    start_frame(780, 50);
    scan(770, 799, 45, 95, 780, 50, 9999, 0, 0, 1'b0, -1, -1);
    // frame 4: reset in the middle of line 70
    start_frame(100, 50);
    scan(90, 149, 45, 75, 100, 50, 9999, 0, 0, 1'b0, 70, 120);
    // frame 5: normal operation resumes after frame_start
    start_frame(100, 50);
    scan(90, 149, 48, 52, 100, 50, 9999, 0, 0, 1'b0, -1, -1);
    // frame 6: frame_start coincides with the icon's top-left pixel
    for (int h = 95; h <= 120; h++) step(1'b1, h, 50, h == 100, 100, 50);
    for (int b = 0; b < 2; b++) step(1'b0, 121 + b, 50, 1'b0, 100, 50);

    // randomized frames: random ROM, position, pixel gaps and position noise
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 2048; i++)
        rom[i] = ($urandom_range(7) == 0) ? 8'hFF : 8'($urandom_range(254));
      rx = $urandom_range(150);
      ry = $urandom_range(40);
      start_frame(rx, ry);
      scan((rx >= 5) ? rx - 5 : 0, rx + 44, (ry >= 3) ? ry - 3 : 0, ry + 42,
           rx, ry, 9999, 0, 0, 1'b1, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
